// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a 32-bit immediate into an instruction word.
// Two-stage valid/ready pipeline; S1 holds fields and checks the immediate, S2 holds the packed word.
module instr_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic        s1_err;
  logic [31:0] s1_word;

  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Signed-range checks: every bit above the format's sign bit must equal the sign bit.
  assign fits_12 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign fits_13 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
  assign fits_21 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

  always_comb begin
    s1_err = 1'b0;
    case (s1_fmt)
      FMT_R:        s1_err = 1'b0;
      FMT_I, FMT_S: s1_err = !fits_12;
      FMT_B:        s1_err = !fits_13 || s1_imm[0];
      FMT_U:        s1_err = |s1_imm[11:0];
      FMT_J:        s1_err = !fits_21 || s1_imm[0];
      default:      s1_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_word = 32'h0000_0000;
    case (s1_fmt)
      FMT_R: s1_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: s1_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                        s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: s1_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: s1_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                        s1_rd, s1_opcode};
      default: s1_word = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= 3'd0;
      s1_opcode <= 7'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_funct7 <= 7'd0;
      s1_imm    <= 32'd0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt    <= in_fmt;
        s1_opcode <= in_opcode;
        s1_rd     <= in_rd;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_funct3 <= in_funct3;
        s1_funct7 <= in_funct7;
        s1_imm    <= in_imm;
      end
    end
  end

  // An illegal word is emitted as all-zeros, which RV32I guarantees to be an illegal instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= s1_err ? 32'h0000_0000 : s1_word;
        out_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected words filled on input
// handshakes and drained by a monitor on output handshakes.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  err_cnt;
  logic        err_clr;

  logic [32:0] sb_q[$];
  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  instr_encoder #(.ERR_CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
    int v;
    logic ok;
    logic [31:0] w;
    v  = $signed(imm);
    ok = 1'b0;
    w  = 32'h0;
    case (f)
      3'd0: begin ok = 1'b1; w = {f7, rs2, rs1, f3, rd, op}; end
      3'd1: begin ok = (v >= -2048 && v <= 2047); w = {imm[11:0], rs1, f3, rd, op}; end
      3'd2: begin ok = (v >= -2048 && v <= 2047); w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      3'd3: begin
        ok = (v >= -4096 && v <= 4094 && !imm[0]);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      3'd4: begin ok = (imm[11:0] == 12'h000); w = {imm[31:12], rd, op}; end
      3'd5: begin
        ok = (v >= -(1 << 20) && v <= (1 << 20) - 2 && !imm[0]);
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0};
  endfunction

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic push_exp();
    sb_q.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
  endtask

  // Hold the presented word until accepted; exp is what the scoreboard must see for it.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic [32:0] exp);
    logic done;
    done = 1'b0;
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("send_accept", {31'b0, done}, 32'd1);
  endtask

  task automatic send_m(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    send(f, op, rd, rs1, rs2, f3, f7, imm, model(f, op, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 60 && !empty; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) empty = 1'b1;
    end
    @(posedge clk); #1;
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic set_word(input int k);
    case (k)
      0: drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
      1: drive(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, -32'sd8);
      2: drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -32'sd4096);
      default: drive(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDE000);
    endcase
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty_on_out", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("out_instr", out_instr, e[31:0]);
        chk("out_err", {31'b0, out_err}, {31'b0, e[32]});
        n_out++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int k;
    int n_before;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;

    // reset state
    @(posedge clk); @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_err_cnt", {30'b0, err_cnt}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // T1: addi x1, x0, -1 with two-clock latency
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    sb_q.push_back({1'b0, 32'hFFF00093});
    @(posedge clk); #1 idle();
    chk("t1_lat_edge1", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_edge2", {31'b0, out_valid}, 32'd1);
    chk("t1_instr", out_instr, 32'hFFF00093);
    drain();

    // T2: jal x0, -4 plus format boundaries
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd4, {1'b0, 32'hFFDFF06F});
    send_m(3'd3, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'h00, 32'd4094);
    send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048574);
    send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd1048576);
    send_m(3'd2, 7'h23, 5'd0, 5'd9, 5'd10, 3'd2, 7'h00, 32'd2047);
    idle();
    drain();

    // T3: range and alignment errors, then the most negative legal I immediate
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, {1'b1, 32'h0});
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3, {1'b1, 32'h0});
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, {1'b1, 32'h0});
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd2048, {1'b0, 32'h80000093});
    idle();
    drain();
    chk("t3_err_cnt", {30'b0, err_cnt}, 32'd3);

    // T5: saturation, then clear racing an error handshake
    send_m(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    send_m(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001);
    send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576);
    idle();
    drain();
    chk("t5_err_sat", {30'b0, err_cnt}, 32'd3);
    out_ready = 1'b0;
    send_m(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    idle();
    @(posedge clk); #1;
    chk("t5_held_valid", {31'b0, out_valid}, 32'd1);
    err_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("t5_clr_priority", {30'b0, err_cnt}, 32'd0);
    send_m(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5000);
    idle();
    drain();
    chk("t5_count_after_clr", {30'b0, err_cnt}, 32'd1);

    // T4: backpressure with four words offered for six clocks
    out_ready = 1'b0;
    k = 0;
    set_word(0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready) begin push_exp(); k++; end
      @(posedge clk); #1;
      if (k < 4) set_word(k);
    end
    @(negedge clk);
    chk("t4_accepted", 32'(k), 32'd2);
    chk("t4_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t4_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_head_stable", out_instr, sb_q[0][31:0]);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_back_to_back", {31'b0, out_valid}, 32'd1);
      if (in_valid && in_ready) begin push_exp(); k++; end
      @(posedge clk); #1;
      if (k < 4) set_word(k); else idle();
    end
    chk("t4_all_accepted", 32'(k), 32'd4);
    idle();
    drain();

    // T6: reset with two words buffered
    out_ready = 1'b0;
    send_m(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0);
    send_m(3'd4, 7'h37, 5'd8, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
    idle();
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_instr", out_instr, 32'h0);
    sb_q.delete();
    n_before = n_out;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    idle();
    drain();
    chk("t6_out_count", 32'(n_out - n_before), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
